keypad_debounce_fsm: RTL and testbench
======================================

KEYPAD_DEBOUNCE_FSM -- requirements
Module: keypad_debounce_fsm

Interface
REQ-001 SHALL have parameter DEBOUNCE_WINDOWS, default 16, meaning the number of consecutive 4-cycle scan windows needed to accept a press or a release.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port row_stable, input, 4 bits: synchronized keypad rows, active-high.
REQ-005 SHALL have port col_stable, input, 4 bits: synchronized one-hot column drive, aligned with row_stable.
REQ-006 SHALL have port enable_scan, output, 1 bit: column-scan enable sent to the scanner.
REQ-007 SHALL have port key_code, output, 4 bits: hex code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse on key acceptance.
REQ-009 SHALL have port key_held, output, 1 bit: high while the accepted key is considered pressed.

Function
REQ-010 SHALL drive enable_scan high in every state; it is low only while reset is asserted.
REQ-011 SHALL keep a free-running 2-bit window counter, cleared by reset; a window is each group of 4 cycles, ending when the counter equals 3.
REQ-012 SHALL define a sample as a hit when the sampled row_stable and col_stable equal the captured row/col; the window is present if any of its 4 samples is a hit.
REQ-013 SHALL use these states: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
REQ-014 In IDLE, the first cycle with row_stable != 0 and col_stable one-hot SHALL capture the row/col pair, clear the debounce count, and go to DB_PRESS.
REQ-015 If row_stable has several bits set, the lowest-index set bit SHALL be captured.
REQ-016 In DB_PRESS, at each window end: if the window was present, increment the count; if it reaches DEBOUNCE_WINDOWS, go to PRESSED; if the window was absent, go to IDLE.
REQ-017 On entry to PRESSED, key_code SHALL update and key_valid SHALL pulse high for exactly one cycle.
REQ-018 In PRESSED, an absent window SHALL clear the count and move to DB_RELEASE.
REQ-019 In DB_RELEASE, absent windows SHALL increment the count; reaching DEBOUNCE_WINDOWS goes to IDLE; a present window returns to PRESSED with no new key_valid.
REQ-020 key_held SHALL be high in the PRESSED and DB_RELEASE states only.
REQ-021 Key map, rows 0-3 by columns 0-3: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-022 A different key pressed while in PRESSED SHALL be ignored until the state returns to IDLE (no rollover).
REQ-023 The debounce counter SHALL be $clog2(DEBOUNCE_WINDOWS+1) bits wide and saturate, never wrapping.

Reset
REQ-024 On a clk edge with reset low: state = IDLE, all counters = 0, captured row/col = 0, key_code = 0, key_valid = 0, key_held = 0, enable_scan = 0.
REQ-025 Reset during any state SHALL abort the operation with no key_valid pulse; normal operation resumes on the first edge after reset goes high.

Configuration
REQ-026 Macro KEYPAD_MULTIKEY_REJECT_EN: when defined, a sample with more than one row_stable bit set is neither captured nor a hit. When undefined, REQ-015 applies.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum type, the window length constant (4), and the 16-entry key-code lookup constants.
REQ-028 Sub-module keypad_key_decode SHALL map the captured one-hot row/col to key_code.

Verification
REQ-029 Hold row 0001 aligned with col 0010 for 16 full windows -> one key_valid pulse, key_code = 0x2, key_held = 1.
REQ-030 Row 1000 with col 1000, removed after 5 windows -> return to IDLE, no key_valid.
REQ-031 Accept key 0x5, then bounce release (absent 3 windows, present 1, absent 16) -> key_held stays 1 until the 16th absent window, only one key_valid in total.
REQ-032 Rows 0011 with col 0001: macro defined -> no acceptance; macro undefined -> key_code = 0x1.
REQ-033 Assert reset in the 10th window of DB_PRESS -> all outputs 0 next edge; no key_valid after release.
REQ-034 Hold key 0x9, then press 0xA while in PRESSED -> no new pulse; 0xA is accepted only after the 0x9 release completes and the state re-enters IDLE.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad debounce FSM.
// State enum, scan-window length and the 4x4 key-code lookup table.
package keypad_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } kp_state_e;

    // One scan window covers one pass over all four columns
    localparam int unsigned WINDOW_LEN = 4;

    // Key codes indexed by {row_idx, col_idx}
    //   row 0: 1 2 3 A
    //   row 1: 4 5 6 B
    //   row 2: 7 8 9 C
    //   row 3: E 0 F D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Isolate the lowest set bit of a 4-bit vector (zero stays zero)
    function automatic logic [3:0] lowest_set_bit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// Maps a captured one-hot row/col pair to its hex key code.
// A pair that is not one-hot in both dimensions decodes to 0.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [3:0] row_onehot,
    input  logic [3:0] col_onehot,
    output logic [3:0] key_code
);

    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic       pair_ok;

    // Convert one-hot row/col to indices and look up the key code
    always_comb begin
        row_idx = '0;
        col_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (row_onehot[i]) begin
                row_idx = 2'(i);
            end
            if (col_onehot[i]) begin
                col_idx = 2'(i);
            end
        end
        pair_ok  = $onehot(row_onehot) && $onehot(col_onehot);
        key_code = pair_ok ? KEY_MAP[{row_idx, col_idx}] : '0;
    end

endmodule

// File: rtl/keypad_debounce_fsm.sv
// Keypad debounce FSM: captures a row/col pair, confirms it over
// DEBOUNCE_WINDOWS consecutive 4-cycle scan windows, reports the key once,
// then debounces the release the same way. No rollover: other keys are
// ignored until the FSM is back in IDLE.
// Optional macro KEYPAD_MULTIKEY_REJECT_EN: a sample with more than one
// row bit set is neither captured nor counted as a hit. Without it, the
// lowest set row bit is used.
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_WINDOWS = 16
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_stable,
    input  logic [3:0] col_stable,
    output logic       enable_scan,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_WINDOWS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_WINDOWS);
    localparam logic [1:0]        WIN_LAST = 2'(WINDOW_LEN - 1);

    kp_state_e        state_q,     state_d;
    logic [1:0]       win_q,       win_d;
    logic             present_q,   present_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [3:0]       row_cap_q,   row_cap_d;
    logic [3:0]       col_cap_q,   col_cap_d;
    logic [3:0]       key_code_q,  key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             enable_q,    enable_d;

    logic [3:0]       row_sel;
    logic             sample_ok;
    logic             sample_hit;
    logic             win_end;
    logic             win_present;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       decoded_code;

    keypad_key_decode u_decode (
        .row_onehot (row_cap_q),
        .col_onehot (col_cap_q),
        .key_code   (decoded_code)
    );

    // Reduce the sampled rows to a single candidate row (or none)
    always_comb begin
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        row_sel = $onehot(row_stable) ? row_stable : '0;
`else
        row_sel = lowest_set_bit(row_stable);
`endif
    end

    // Per-cycle sample qualification and window bookkeeping
    always_comb begin
        sample_ok = (row_sel != '0) && $onehot(col_stable);
        // In IDLE the capturing sample itself counts towards the first window
        if (state_q == IDLE) begin
            sample_hit = sample_ok;
        end else begin
            sample_hit = (row_sel == row_cap_q) && (col_stable == col_cap_q);
        end
        win_end     = (win_q == WIN_LAST);
        win_present = present_q | sample_hit;
        cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_cap_d   = row_cap_q;
        col_cap_d   = col_cap_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        enable_d    = 1'b1;
        win_d       = win_q + 2'd1;
        present_d   = win_end ? 1'b0 : win_present;

        unique case (state_q)
            IDLE: begin
                if (sample_ok) begin
                    row_cap_d = row_sel;
                    col_cap_d = col_stable;
                    cnt_d     = '0;
                    state_d   = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (win_end) begin
                    if (win_present) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d     = PRESSED;
                            key_valid_d = 1'b1;
                            key_code_d  = decoded_code;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            PRESSED: begin
                if (win_end && !win_present) begin
                    cnt_d   = '0;
                    state_d = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (win_end) begin
                    if (win_present) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            win_q       <= '0;
            present_q   <= 1'b0;
            cnt_q       <= '0;
            row_cap_q   <= '0;
            col_cap_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            present_q   <= present_d;
            cnt_q       <= cnt_d;
            row_cap_q   <= row_cap_d;
            col_cap_q   <= col_cap_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            enable_q    <= enable_d;
        end
    end

    assign enable_scan = enable_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_held    = (state_q == PRESSED) || (state_q == DB_RELEASE);

endmodule

// File: tb/tb_keypad_debounce_fsm.sv
// Testbench for keypad_debounce_fsm: directed scenarios plus randomized
// scanning, each cycle compared with a behavioural model of the keypad rules.
module tb_keypad_debounce_fsm;

    localparam int DW = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_stable;
    logic [3:0] col_stable;
    logic       enable_scan;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_checks  = 0;
    int n_errors  = 0;
    bit chk_en    = 1'b0;
    int pulse_cnt = 0;
    int scan_idx  = 0;

    keypad_debounce_fsm #(.DEBOUNCE_WINDOWS(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .row_stable  (row_stable),
        .col_stable  (col_stable),
        .enable_scan (enable_scan),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Modes: 0 waiting, 1 confirming press, 2 key down, 3 confirming release
    int         m_cyc = 0;
    bit         m_hits[$];
    int         m_mode = 0;
    int         m_windows = 0;
    int         m_row = -1;
    int         m_col = -1;
    logic [3:0] m_code = 4'h0;
    bit         m_valid = 1'b0;
    bit         m_enable = 1'b0;
    int         keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11},
                                  '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    always @(posedge clk) begin
        int  r_idx, n_rows, c_idx, n_cols;
        bit  hit, any;
        r_idx = -1; n_rows = 0; c_idx = -1; n_cols = 0;
        for (int i = 0; i < 4; i++) begin
            if (row_stable[i]) begin
                n_rows++;
                if (r_idx < 0) r_idx = i;
            end
            if (col_stable[i]) begin
                n_cols++;
                c_idx = i;
            end
        end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        if (n_rows > 1) r_idx = -1;
`endif
        if (!reset) begin
            m_cyc = 0; m_hits.delete(); m_mode = 0; m_windows = 0;
            m_row = -1; m_col = -1; m_code = 4'h0; m_valid = 1'b0; m_enable = 1'b0;
        end else begin
            m_enable = 1'b1;
            m_valid  = 1'b0;
            if (m_mode == 0) hit = (r_idx >= 0) && (n_cols == 1);
            else             hit = (r_idx == m_row) && (n_cols == 1) && (c_idx == m_col);
            m_hits.push_back(hit);
            any = 1'b0;
            foreach (m_hits[k]) if (m_hits[k]) any = 1'b1;
            if (m_mode == 0) begin
                if (hit) begin
                    m_row = r_idx; m_col = c_idx; m_windows = 0; m_mode = 1;
                end
            end else if (m_cyc % 4 == 3) begin
                if (m_mode == 1) begin
                    if (any) begin
                        m_windows++;
                        if (m_windows >= DW) begin
                            m_mode = 2; m_valid = 1'b1;
                            m_code = 4'(keymap[m_row][m_col]);
                        end
                    end else m_mode = 0;
                end else if (m_mode == 2) begin
                    if (!any) begin m_windows = 0; m_mode = 3; end
                end else begin
                    if (any) begin m_windows = 0; m_mode = 2; end
                    else begin
                        m_windows++;
                        if (m_windows >= DW) m_mode = 0;
                    end
                end
            end
            if (m_cyc % 4 == 3) m_hits.delete();
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("enable_scan", 32'(enable_scan), 32'(m_enable));
            check("key_valid",   32'(key_valid),   32'(m_valid));
            check("key_held",    32'(key_held),    32'((m_mode == 2) || (m_mode == 3)));
            check("key_code",    32'(key_code),    32'(m_code));
            if (key_valid === 1'b1) pulse_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold(input logic [3:0] r, input logic [3:0] c, input int n);
        row_stable = r;
        col_stable = c;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Column scanner: keys bit (row*4 + col) set means that key is down
    task automatic scan(input logic [15:0] keys, input int n);
        repeat (n) begin
            int c;
            c = scan_idx % 4;
            col_stable = 4'b0001 << c;
            for (int r = 0; r < 4; r++) row_stable[r] = keys[r*4 + c];
            scan_idx++;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; row_stable = '0; col_stable = '0;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] keys;
        int          kind;
        reset = 1'b0; row_stable = '0; col_stable = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_enable", 32'(enable_scan), 32'd0);
        check("rst_valid",  32'(key_valid),   32'd0);
        check("rst_held",   32'(key_held),    32'd0);
        check("rst_code",   32'(key_code),    32'd0);
        reset = 1'b1;

        // Key 2 held for well over 16 windows
        pulse_cnt = 0;
        hold(4'b0001, 4'b0010, 17*4);
        check("k2_pulses", 32'(pulse_cnt), 32'd1);
        check("k2_code",   32'(key_code),  32'h2);
        check("k2_held",   32'(key_held),  32'd1);
        hold(4'b0000, 4'b0000, 18*4);
        check("k2_released", 32'(key_held), 32'd0);

        // Key D removed after 5 windows: never accepted
        pulse_cnt = 0;
        hold(4'b1000, 4'b1000, 5*4);
        check("kd_not_held", 32'(key_held), 32'd0);
        hold(4'b0000, 4'b0000, 8);
        check("kd_pulses", 32'(pulse_cnt), 32'd0);
        check("kd_idle",   32'(key_held),  32'd0);

        // Key 5 with a bouncing release
        pulse_cnt = 0;
        hold(4'b0010, 4'b0010, 17*4);
        check("k5_pulses", 32'(pulse_cnt), 32'd1);
        check("k5_code",   32'(key_code),  32'h5);
        hold(4'b0000, 4'b0000, 12);
        check("k5_bounce_held1", 32'(key_held), 32'd1);
        hold(4'b0010, 4'b0010, 4);
        check("k5_bounce_held2", 32'(key_held), 32'd1);
        hold(4'b0000, 4'b0000, 56);
        check("k5_bounce_held3", 32'(key_held), 32'd1);
        hold(4'b0000, 4'b0000, 12);
        check("k5_release_done", 32'(key_held), 32'd0);
        check("k5_total_pulses", 32'(pulse_cnt), 32'd1);

        // Two rows in one column
        pulse_cnt = 0;
        hold(4'b0011, 4'b0001, 17*4);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        check("multi_pulses", 32'(pulse_cnt), 32'd0);
        check("multi_held",   32'(key_held),  32'd0);
`else
        check("multi_pulses", 32'(pulse_cnt), 32'd1);
        check("multi_code",   32'(key_code),  32'h1);
        check("multi_held",   32'(key_held),  32'd1);
`endif
        hold(4'b0000, 4'b0000, 18*4);

        // Reset in the middle of press debounce
        pulse_cnt = 0;
        hold(4'b0001, 4'b0100, 38);
        check("abort_not_held", 32'(key_held), 32'd0);
        reset = 1'b0; row_stable = '0; col_stable = '0;
        @(posedge clk); #1;
        check("abort_valid",  32'(key_valid),   32'd0);
        check("abort_held",   32'(key_held),    32'd0);
        check("abort_enable", 32'(enable_scan), 32'd0);
        check("abort_code",   32'(key_code),    32'd0);
        reset = 1'b1;
        hold(4'b0000, 4'b0000, 12);
        check("abort_pulses", 32'(pulse_cnt),   32'd0);
        check("abort_resume", 32'(enable_scan), 32'd1);

        // No rollover: 9 held, A added, 9 released
        pulse_cnt = 0;
        scan(16'h0400, 17*4);
        check("k9_pulses", 32'(pulse_cnt), 32'd1);
        check("k9_code",   32'(key_code),  32'h9);
        scan(16'h0408, 17*4);
        check("roll_pulses", 32'(pulse_cnt), 32'd1);
        check("roll_code",   32'(key_code),  32'h9);
        check("roll_held",   32'(key_held),  32'd1);
        scan(16'h0008, 56);
        check("ka_early_pulses", 32'(pulse_cnt), 32'd1);
        check("ka_early_held",   32'(key_held),  32'd1);
        scan(16'h0008, 96);
        check("ka_pulses", 32'(pulse_cnt), 32'd2);
        check("ka_code",   32'(key_code),  32'hA);
        check("ka_held",   32'(key_held),  32'd1);
        scan(16'h0000, 18*4);

        // Randomized scanning, noise and resets; checked every cycle
        for (int seg = 0; seg < 40; seg++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else if (kind == 1) begin
                hold(4'($urandom), 4'($urandom), int'($urandom_range(1, 12)));
            end else begin
                keys = '0;
                if (kind >= 4) keys = 16'd1 << $urandom_range(0, 15);
                if (kind >= 8) keys = keys | (16'd1 << $urandom_range(0, 15));
                scan(keys, int'($urandom_range(4, 100)));
            end
        end
        hold(4'b0000, 4'b0000, 4);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
